// File: rtl/vga_pkg.sv
// Shared constants and types for the framebuffer arbiter slice.
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int FB_WORDS    = FB_W * FB_H;

  localparam int ADDR_W = 15;
  localparam int RGB_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// Writer handshake plus single-port RAM bus seen by the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fb_arbiter_if;
  import vga_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_x;
  logic [6:0]        wr_y;
  logic [RGB_W-1:0]  wr_rgb;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [RGB_W-1:0]  ram_wdata;
  logic [RGB_W-1:0]  ram_rdata;

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, ram_rdata,
    output wr_ready, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, ram_rdata,
    input  wr_ready, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address y*160 + x built from shifts and adds.
module fb_addr_calc
  import vga_pkg::*;
(
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic [ADDR_W-1:0] addr
);

  // y*160 = y*128 + y*32
  assign addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};

endmodule

// File: rtl/fb_arbiter.sv
// Shares the single-port framebuffer between VGA scanout (fixed slot on
// every active pixel strobe), a clear-screen sweeper and a drawing writer.
module fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
  parameter int FB_W        = vga_pkg::FB_W,
  parameter int FB_H        = vga_pkg::FB_H,
  parameter int FB_WORDS    = vga_pkg::FB_WORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             clr_req,
  input  logic [RGB_W-1:0] clr_rgb,
  output logic             clr_busy,
  output logic [RGB_W-1:0] rgb,
  fb_arbiter_if.slave      bus
);

  localparam logic [9:0]        H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
  localparam logic [7:0]        X_LIM     = 8'(FB_W);
  localparam logic [6:0]        Y_LIM     = 7'(FB_H);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(FB_WORDS - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [RGB_W-1:0]  clr_rgb_q, clr_rgb_d;
  logic              vld_p1_q, vld_p1_d;
  logic              blank_p1_q, blank_p1_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;

  logic              active;
  logic              scan_slot;
  logic              wr_in_range;
  logic [7:0]        scan_x;
  logic [6:0]        scan_y;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] wr_addr;

  // Scan coordinates only need to be valid inside the active region.
  assign scan_x = 8'(h_count >> SCALE_SHIFT);
  assign scan_y = 7'(v_count >> SCALE_SHIFT);

  fb_addr_calc u_scan_addr (.x(scan_x),   .y(scan_y),   .addr(scan_addr));
  fb_addr_calc u_wr_addr   (.x(bus.wr_x), .y(bus.wr_y), .addr(wr_addr));

  assign active      = (h_count < H_LIM) && (v_count < V_LIM);
  assign scan_slot   = pix_ce & active;
  assign wr_in_range = (bus.wr_x < X_LIM) && (bus.wr_y < Y_LIM);

  assign clr_busy = (state_q == CLEAR);
  assign rgb      = rgb_q;

  // RAM port mux: scan slot first, then sweeper, then writer.
  always_comb begin
    bus.wr_ready  = rst_n & ~scan_slot & (state_q == IDLE);
    bus.ram_addr  = wr_addr;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = bus.wr_rgb;
    if (scan_slot) begin
      bus.ram_addr = scan_addr;
    end else if (state_q == CLEAR) begin
      bus.ram_addr  = clr_cnt_q;
      bus.ram_we    = rst_n;
      bus.ram_wdata = clr_rgb_q;
    end else if (bus.wr_valid) begin
      bus.ram_we = rst_n & wr_in_range;
    end
  end

  // Clear sweeper FSM: start on request, walk every word once, then idle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_rgb_d = clr_rgb_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          clr_rgb_d = clr_rgb;
        end
      end
      CLEAR: begin
        if (!scan_slot) begin
          if (clr_cnt_q == CLR_LAST) state_d = IDLE;
          else                       clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel pipe: read data arrives one cycle after the strobe, blank strobes force black.
  always_comb begin
    vld_p1_d   = scan_slot;
    blank_p1_d = pix_ce & ~active;
    rgb_d      = rgb_q;
    if (vld_p1_q)        rgb_d = bus.ram_rdata;
    else if (blank_p1_q) rgb_d = '0;
  end

  // State, sweeper and pixel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_rgb_q  <= '0;
      vld_p1_q   <= 1'b0;
      blank_p1_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_rgb_q  <= clr_rgb_d;
      vld_p1_q   <= vld_p1_d;
      blank_p1_q <= blank_p1_d;
      rgb_q      <= rgb_d;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic [9:0] h_count, v_count;
  logic       clr_req;
  logic [2:0] clr_rgb;
  logic       clr_busy;
  logic [2:0] rgb;

  int checks = 0;
  int errors = 0;

  fb_arbiter_if bus ();

  fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .h_count(h_count), .v_count(v_count),
    .clr_req(clr_req), .clr_rgb(clr_rgb), .clr_busy(clr_busy), .rgb(rgb), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [2:0] mem [0:32767];
  logic [2:0] rdata_q = 3'd0;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    rdata_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = rdata_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    h_count = 10'd700; v_count = 10'd0; pix_ce = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_x = x; bus.wr_y = y; bus.wr_rgb = c;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_ce = 1'b0; h_count = 10'd700; v_count = 10'd0;
    clr_req = 1'b0; clr_rgb = 3'd0;
    bus.wr_valid = 1'b1; bus.wr_x = 8'd0; bus.wr_y = 7'd0; bus.wr_rgb = 3'd1;
    tick(); tick();
    checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL reset_rgb: got %0d expected 0", rgb); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", clr_busy); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %0b expected 0", bus.wr_ready); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %0b expected 0", bus.ram_we); end
    rst_n = 1'b1; bus.wr_valid = 1'b0;
    tick();
  endtask

  task automatic test_scanout();
    write_px(8'd0, 7'd0, 3'b101);
    write_px(8'd1, 7'd1, 3'b010);
    h_count = 10'd0; v_count = 10'd0; pix_ce = 1'b1;
    #1;
    checks++; if (bus.ram_addr !== 15'd0) begin errors++; $display("FAIL scan0_addr: got %0d expected 0", bus.ram_addr); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL scan0_we: got %0b expected 0", bus.ram_we); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL scan0_wr_ready: got %0b expected 0", bus.wr_ready); end
    tick(); pix_ce = 1'b0; #1;
    checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL scan0_rgb_t1: got %0d expected 0", rgb); end
    tick(); #1;
    checks++; if (rgb !== 3'b101) begin errors++; $display("FAIL scan0_rgb_t2: got %0d expected 5", rgb); end
    h_count = 10'd4; v_count = 10'd4; pix_ce = 1'b1; #1;
    checks++; if (bus.ram_addr !== 15'd161) begin errors++; $display("FAIL scan161_addr: got %0d expected 161", bus.ram_addr); end
    tick(); pix_ce = 1'b0;
    tick(); #1;
    checks++; if (rgb !== 3'b010) begin errors++; $display("FAIL scan161_rgb: got %0d expected 2", rgb); end
    tick(); tick(); #1;
    checks++; if (rgb !== 3'b010) begin errors++; $display("FAIL scan_hold: got %0d expected 2", rgb); end
  endtask

  task automatic test_blanking();
    h_count = 10'd700; v_count = 10'd4; pix_ce = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_x = 8'd2; bus.wr_y = 7'd0; bus.wr_rgb = 3'd6;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL blank_wr_ready: got %0b expected 1", bus.wr_ready); end
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 15'd2) begin
      errors++; $display("FAIL blank_write: got we=%0b addr=%0d expected we=1 addr=2", bus.ram_we, bus.ram_addr); end
    tick(); pix_ce = 1'b0; bus.wr_valid = 1'b0;
    tick(); #1;
    checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL blank_rgb: got %0d expected 0", rgb); end
    checks++; if (mem[2] !== 3'd6) begin errors++; $display("FAIL blank_mem2: got %0d expected 6", mem[2]); end
  endtask

  task automatic test_contention();
    int grants = 0;
    int bad = 0;
    v_count = 10'd8;
    bus.wr_valid = 1'b1; bus.wr_x = 8'd3; bus.wr_y = 7'd0; bus.wr_rgb = 3'd1;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        h_count = 10'(8 + p * 4); pix_ce = (c == 0); #1;
        if (bus.wr_ready !== !pix_ce) bad++;
        if (bus.ram_we === 1'b1) grants++;
        tick();
      end
    end
    bus.wr_valid = 1'b0; pix_ce = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL contention_ready: got %0d bad cycles expected 0", bad); end
    checks++; if (grants !== 9) begin errors++; $display("FAIL contention_writes: got %0d expected 9", grants); end
  endtask

  task automatic test_writer();
    h_count = 10'd700; v_count = 10'd0; pix_ce = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_x = 8'd159; bus.wr_y = 7'd119; bus.wr_rgb = 3'b011; #1;
    checks++; if (bus.ram_addr !== 15'd19199 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 3'b011) begin
      errors++; $display("FAIL wr_last: got addr=%0d we=%0b data=%0d expected 19199/1/3", bus.ram_addr, bus.ram_we, bus.ram_wdata); end
    tick();
    checks++; if (mem[19199] !== 3'b011) begin errors++; $display("FAIL wr_last_mem: got %0d expected 3", mem[19199]); end
    bus.wr_x = 8'd160; bus.wr_y = 7'd0; #1;
    checks++; if (bus.wr_ready !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL wr_x_oob: got ready=%0b we=%0b expected 1/0", bus.wr_ready, bus.ram_we); end
    bus.wr_x = 8'd0; bus.wr_y = 7'd120; #1;
    checks++; if (bus.wr_ready !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL wr_y_oob: got ready=%0b we=%0b expected 1/0", bus.wr_ready, bus.ram_we); end
    tick(); bus.wr_valid = 1'b0;
  endtask

  task automatic test_clear();
    int exp_addr = 0;
    int bad = 0;
    int rdy_bad = 0;
    int fall = -1;
    int not_white = 0;
    logic strobe;
    h_count = 10'd700; v_count = 10'd0; pix_ce = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_x = 8'd1; bus.wr_y = 7'd1; bus.wr_rgb = 3'd4;
    clr_req = 1'b1; clr_rgb = 3'b111; #1;
    checks++; if (bus.wr_ready !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 15'd161) begin
      errors++; $display("FAIL clr_same_cycle_wr: got ready=%0b we=%0b addr=%0d expected 1/1/161", bus.wr_ready, bus.ram_we, bus.ram_addr); end
    tick();
    for (int k = 0; k < 20000; k++) begin
      clr_req = (k == 100);
      clr_rgb = (k == 100) ? 3'd2 : 3'b111;
      strobe  = (k == 200) || (k == 204) || (k == 208);
      pix_ce  = strobe;
      h_count = strobe ? 10'd0 : 10'd700;
      #1;
      if (clr_busy !== 1'b1) begin fall = k; break; end
      if (bus.wr_ready !== 1'b0) rdy_bad++;
      if (strobe) begin
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 15'd0) bad++;
      end else begin
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 15'(exp_addr) || bus.ram_wdata !== 3'b111) bad++;
        exp_addr++;
      end
      tick();
    end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL clr_wr_resume: got %0b expected 1", bus.wr_ready); end
    bus.wr_valid = 1'b0; clr_req = 1'b0; pix_ce = 1'b0; h_count = 10'd700;
    checks++; if (fall !== 19203) begin errors++; $display("FAIL clr_busy_fall: got cycle %0d expected 19203", fall); end
    checks++; if (exp_addr !== 19200) begin errors++; $display("FAIL clr_write_count: got %0d expected 19200", exp_addr); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clr_sequence: got %0d bad cycles expected 0", bad); end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL clr_wr_ready: got %0d granted cycles expected 0", rdy_bad); end
    tick();
    for (int a = 0; a < 19200; a++) if (mem[a] !== 3'b111) not_white++;
    checks++; if (not_white !== 0) begin errors++; $display("FAIL clr_contents: got %0d non-white words expected 0", not_white); end
  endtask

  task automatic test_reset_mid_clear();
    int found = 0;
    v_count = 10'd0; h_count = 10'd0; pix_ce = 1'b1;
    tick(); pix_ce = 1'b0; h_count = 10'd700;
    tick(); #1;
    checks++; if (rgb !== 3'b111) begin errors++; $display("FAIL rmc_pre_rgb: got %0d expected 7", rgb); end
    clr_req = 1'b1; clr_rgb = 3'd5;
    tick(); clr_req = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      #1;
      if (bus.ram_we === 1'b1 && bus.ram_addr === 15'd5000) begin found = 1; break; end
      tick();
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL rmc_reach_5000: got %0d expected 1", found); end
    rst_n = 1'b0; #1;
    checks++; if (clr_busy !== 1'b0 || rgb !== 3'd0 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL rmc_reset: got busy=%0b rgb=%0d we=%0b expected 0/0/0", clr_busy, rgb, bus.ram_we); end
    tick(); rst_n = 1'b1;
    tick();
    clr_req = 1'b1; clr_rgb = 3'd1;
    tick(); clr_req = 1'b0; #1;
    checks++; if (clr_busy !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 15'd0) begin
      errors++; $display("FAIL rmc_restart: got busy=%0b we=%0b addr=%0d expected 1/1/0", clr_busy, bus.ram_we, bus.ram_addr); end
  endtask

  initial begin
    test_reset();
    test_scanout();
    test_blanking();
    test_contention();
    test_writer();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
